// File: rtl/timer_pkg.sv
// Shared constants for the timer counting engine.
// Optional one-shot build is selected with the TMR_ONESHOT_EN macro.
package timer_pkg;

    localparam int unsigned CNT_W_DEF = 8;
    localparam int unsigned PSC_W_DEF = 4;

    // Clock select encodings: divide pclk by 2^(cks+1)
    localparam logic [1:0] CKS_DIV2  = 2'd0;
    localparam logic [1:0] CKS_DIV4  = 2'd1;
    localparam logic [1:0] CKS_DIV8  = 2'd2;
    localparam logic [1:0] CKS_DIV16 = 2'd3;

    // Count direction
    localparam logic DIR_UP = 1'b0;
    localparam logic DIR_DN = 1'b1;

    // Prescaler compare mask for a clock select: 2^(cks+1)-1
    function automatic int unsigned cks_mask(input logic [1:0] cks);
        return (32'd2 << cks) - 32'd1;
    endfunction

endpackage

// File: rtl/timer_counter_core_if.sv
// Control/status bundle between the APB register file and the counting engine.
// The oneshot control only exists when TMR_ONESHOT_EN is defined.
interface timer_counter_core_if #(
    parameter int unsigned CNT_W = 8
);
    logic             en;
    logic             cnt_dn;
    logic [1:0]       cks;
    logic             load;
    logic [CNT_W-1:0] tdr;
    logic             ovf_ie;
    logic             udf_ie;
    logic             ovf_clr;
    logic             udf_clr;
`ifdef TMR_ONESHOT_EN
    logic             oneshot;
`endif
    logic [CNT_W-1:0] tcnt;
    logic             ovf_flag;
    logic             udf_flag;
    logic             tmr_irq;

`ifdef TMR_ONESHOT_EN
    modport master (
        output en, cnt_dn, cks, load, tdr, ovf_ie, udf_ie, ovf_clr, udf_clr, oneshot,
        input  tcnt, ovf_flag, udf_flag, tmr_irq
    );
    modport slave (
        input  en, cnt_dn, cks, load, tdr, ovf_ie, udf_ie, ovf_clr, udf_clr, oneshot,
        output tcnt, ovf_flag, udf_flag, tmr_irq
    );
`else
    modport master (
        output en, cnt_dn, cks, load, tdr, ovf_ie, udf_ie, ovf_clr, udf_clr,
        input  tcnt, ovf_flag, udf_flag, tmr_irq
    );
    modport slave (
        input  en, cnt_dn, cks, load, tdr, ovf_ie, udf_ie, ovf_clr, udf_clr,
        output tcnt, ovf_flag, udf_flag, tmr_irq
    );
`endif

endinterface

// File: rtl/timer_prescaler.sv
// Free-running prescaler producing a one-cycle tick every 2^(cks+1) pclk cycles.
module timer_prescaler
    import timer_pkg::*;
#(
    parameter int unsigned PSC_W = PSC_W_DEF
) (
    input  logic       pclk,
    input  logic       presetn,
    input  logic       en,
    input  logic       load,
    input  logic [1:0] cks,
    output logic       tick
);

    logic [PSC_W-1:0] psc_q;
    logic [PSC_W-1:0] psc_d;
    logic [PSC_W-1:0] mask;

    // Mask follows cks immediately; psc is not cleared on a cks change
    always_comb begin
        mask  = PSC_W'(cks_mask(cks));
        psc_d = (en && !load) ? psc_q + PSC_W'(1) : '0;
        tick  = en && !load && ((psc_q & mask) == mask);
    end

    // Prescaler state with synchronous reset
    always_ff @(posedge pclk) begin
        if (!presetn) begin
            psc_q <= '0;
        end else begin
            psc_q <= psc_d;
        end
    end

endmodule

// File: rtl/timer_counter_core.sv
// 8-bit timer counting engine: prescaled up/down counter, sticky wrap flags, irq.
// Define TMR_ONESHOT_EN to add the oneshot control that stops counting after a wrap.
module timer_counter_core
    import timer_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF,
    parameter int unsigned PSC_W = PSC_W_DEF
) (
    input logic                 pclk,
    input logic                 presetn,
    timer_counter_core_if.slave bus
);

    logic             tick;
    logic             psc_en;
    logic             ovf_evt;
    logic             udf_evt;
    logic [CNT_W-1:0] tcnt_q;
    logic             ovf_q;
    logic             udf_q;

`ifdef TMR_ONESHOT_EN
    logic run_q;
    logic en_q;
    logic run_act;

    // A load or en rising edge restarts a stopped one-shot in the same cycle
    always_comb begin
        run_act = run_q || (bus.en && !en_q) || bus.load;
        psc_en  = bus.en && (run_act || !bus.oneshot);
    end

    // Run tracking: set on load / en rise, cleared by a wrap in one-shot mode
    always_ff @(posedge pclk) begin
        if (!presetn) begin
            run_q <= 1'b0;
            en_q  <= 1'b0;
        end else begin
            en_q <= bus.en;
            if (bus.load || (bus.en && !en_q)) begin
                run_q <= 1'b1;
            end else if (bus.oneshot && (ovf_evt || udf_evt)) begin
                run_q <= 1'b0;
            end
        end
    end
`else
    assign psc_en = bus.en;
`endif

    timer_prescaler #(
        .PSC_W (PSC_W)
    ) u_prescaler (
        .pclk    (pclk),
        .presetn (presetn),
        .en      (psc_en),
        .load    (bus.load),
        .cks     (bus.cks),
        .tick    (tick)
    );

    // Wrap events; tick already excludes load, so a load suppresses them
    always_comb begin
        ovf_evt = tick && (bus.cnt_dn == DIR_UP) && (tcnt_q == '1);
        udf_evt = tick && (bus.cnt_dn == DIR_DN) && (tcnt_q == '0);
    end

    // Counter: load beats tick beats hold
    always_ff @(posedge pclk) begin
        if (!presetn) begin
            tcnt_q <= '0;
        end else if (bus.load) begin
            tcnt_q <= bus.tdr;
        end else if (tick) begin
            tcnt_q <= (bus.cnt_dn == DIR_DN) ? tcnt_q - CNT_W'(1) : tcnt_q + CNT_W'(1);
        end
    end

    // Sticky flags: set wins over clear
    always_ff @(posedge pclk) begin
        if (!presetn) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            if (ovf_evt) begin
                ovf_q <= 1'b1;
            end else if (bus.ovf_clr) begin
                ovf_q <= 1'b0;
            end
            if (udf_evt) begin
                udf_q <= 1'b1;
            end else if (bus.udf_clr) begin
                udf_q <= 1'b0;
            end
        end
    end

    assign bus.tcnt     = tcnt_q;
    assign bus.ovf_flag = ovf_q;
    assign bus.udf_flag = udf_q;
    assign bus.tmr_irq  = (ovf_q && bus.ovf_ie) || (udf_q && bus.udf_ie);

endmodule

// File: tb/tb_timer_counter_core.sv
// Directed self-checking bench for timer_counter_core.
// One-shot checks are included when TMR_ONESHOT_EN is defined.
module tb_timer_counter_core;

    logic pclk = 1'b0;
    logic presetn;
    int   checks   = 0;
    int   failures = 0;

    timer_counter_core_if #(.CNT_W(8)) bus ();

    timer_counter_core #(
        .CNT_W (8),
        .PSC_W (4)
    ) dut (
        .pclk    (pclk),
        .presetn (presetn),
        .bus     (bus)
    );

    always #5 pclk = ~pclk;

    // Advance n rising edges, then settle 1 time unit past the edge
    task automatic step(input int n);
        repeat (n) @(posedge pclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset held with conflicting inputs active
        presetn     = 1'b0;
        bus.en      = 1'b1;
        bus.load    = 1'b1;
        bus.tdr     = 8'hAA;
        bus.cnt_dn  = 1'b0;
        bus.cks     = 2'd0;
        bus.ovf_ie  = 1'b0;
        bus.udf_ie  = 1'b0;
        bus.ovf_clr = 1'b0;
        bus.udf_clr = 1'b0;
`ifdef TMR_ONESHOT_EN
        bus.oneshot = 1'b0;
`endif
        step(2);
        check("rst_tcnt", bus.tcnt, 8'h00);
        check("rst_ovf", {7'd0, bus.ovf_flag}, 8'h00);
        check("rst_udf", {7'd0, bus.udf_flag}, 8'h00);
        check("rst_irq", {7'd0, bus.tmr_irq}, 8'h00);

        presetn  = 1'b1;
        bus.load = 1'b0;
        bus.en   = 1'b0;
        step(1);
        check("idle_tcnt", bus.tcnt, 8'h00);

        // Up count, divide by 2
        bus.en = 1'b1;
        step(2);
        check("up_div2_first", bus.tcnt, 8'h01);
        step(18);
        check("up_div2_20", bus.tcnt, 8'h0A);

        // Reset mid-count
        bus.en   = 1'b0;
        bus.load = 1'b1;
        bus.tdr  = 8'h05;
        step(1);
        check("load_05", bus.tcnt, 8'h05);
        bus.load = 1'b0;
        bus.en   = 1'b1;
        presetn  = 1'b0;
        step(1);
        check("rst_mid", bus.tcnt, 8'h00);
        presetn = 1'b1;

        // Divide by 16
        bus.en = 1'b0;
        step(1);
        bus.en  = 1'b1;
        bus.cks = 2'd3;
        step(15);
        check("div16_15", bus.tcnt, 8'h00);
        step(1);
        check("div16_16", bus.tcnt, 8'h01);

        // Overflow with irq
        bus.load   = 1'b1;
        bus.tdr    = 8'hFE;
        bus.cks    = 2'd0;
        bus.ovf_ie = 1'b1;
        step(1);
        check("ovf_load", bus.tcnt, 8'hFE);
        bus.load = 1'b0;
        step(2);
        check("ovf_ff", bus.tcnt, 8'hFF);
        check("ovf_pre_flag", {7'd0, bus.ovf_flag}, 8'h00);
        step(2);
        check("ovf_wrap", bus.tcnt, 8'h00);
        check("ovf_flag", {7'd0, bus.ovf_flag}, 8'h01);
        check("ovf_irq", {7'd0, bus.tmr_irq}, 8'h01);
        bus.ovf_clr = 1'b1;
        step(1);
        bus.ovf_clr = 1'b0;
        check("ovf_clr_flag", {7'd0, bus.ovf_flag}, 8'h00);
        check("ovf_clr_irq", {7'd0, bus.tmr_irq}, 8'h00);

        // Underflow, divide by 16, irq masked then unmasked
        bus.load   = 1'b1;
        bus.tdr    = 8'h01;
        bus.cks    = 2'd3;
        bus.cnt_dn = 1'b1;
        step(1);
        check("udf_load", bus.tcnt, 8'h01);
        bus.load = 1'b0;
        step(16);
        check("udf_00", bus.tcnt, 8'h00);
        check("udf_pre_flag", {7'd0, bus.udf_flag}, 8'h00);
        step(16);
        check("udf_ff", bus.tcnt, 8'hFF);
        check("udf_flag", {7'd0, bus.udf_flag}, 8'h01);
        check("udf_irq_masked", {7'd0, bus.tmr_irq}, 8'h00);
        bus.udf_ie = 1'b1;
        #1;
        check("udf_irq_unmask", {7'd0, bus.tmr_irq}, 8'h01);

        // Clear coincident with an overflow tick: set wins
        bus.load    = 1'b1;
        bus.tdr     = 8'hFE;
        bus.cks     = 2'd0;
        bus.cnt_dn  = 1'b0;
        bus.udf_clr = 1'b1;
        step(1);
        bus.load    = 1'b0;
        bus.udf_clr = 1'b0;
        check("udf_cleared", {7'd0, bus.udf_flag}, 8'h00);
        step(3);
        check("sim_ff", bus.tcnt, 8'hFF);
        check("sim_ovf_pre", {7'd0, bus.ovf_flag}, 8'h00);
        bus.ovf_clr = 1'b1;
        step(1);
        bus.ovf_clr = 1'b0;
        check("sim_wrap", bus.tcnt, 8'h00);
        check("sim_set_wins", {7'd0, bus.ovf_flag}, 8'h01);

        // Load coincident with a would-be wrap: no event
        bus.ovf_clr = 1'b1;
        step(1);
        bus.ovf_clr = 1'b0;
        bus.load    = 1'b1;
        bus.tdr     = 8'hFF;
        step(1);
        bus.load = 1'b0;
        step(1);
        bus.load = 1'b1;
        bus.tdr  = 8'h33;
        step(1);
        bus.load = 1'b0;
        check("ldtick_tcnt", bus.tcnt, 8'h33);
        check("ldtick_ovf", {7'd0, bus.ovf_flag}, 8'h00);
        check("ldtick_irq", {7'd0, bus.tmr_irq}, 8'h00);

`ifdef TMR_ONESHOT_EN
        // One-shot: stop on wrap, restart on load
        bus.oneshot = 1'b1;
        bus.load    = 1'b1;
        bus.tdr     = 8'hFF;
        step(1);
        bus.load = 1'b0;
        step(2);
        check("os_wrap", bus.tcnt, 8'h00);
        check("os_flag", {7'd0, bus.ovf_flag}, 8'h01);
        step(40);
        check("os_hold", bus.tcnt, 8'h00);
        bus.load = 1'b1;
        bus.tdr  = 8'h10;
        step(1);
        bus.load = 1'b0;
        step(2);
        check("os_restart", bus.tcnt, 8'h11);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/timer_counter_core.md
Name: timer_counter_core

Overview:
- 8-bit counting engine of the timer IP, directly downstream of the system clock/reset generator; runs entirely on pclk/presetn.
- Takes control fields from the APB register file: enable, direction, clock select, load pulse and reload value.
- Produces the live count, sticky overflow/underflow flags and an interrupt line back to the register file.
- Contains a prescaler that divides pclk by 2/4/8/16.

Parameters:
- CNT_W, 8, counter and reload width.
- PSC_W, 4, prescaler width; must be >= 4 to support divide-by-16.

Ports:
- pclk  input  1  system clock; all logic on rising edge.
- presetn  input  1  synchronous active-low reset, sampled on pclk rising edge.
- en  input  1  count enable; while 0, prescaler held at 0 and counter frozen.
- cnt_dn  input  1  direction: 0 = up, 1 = down.
- cks  input  2  clock select: divide pclk by 2^(cks+1).
- load  input  1  single-cycle pulse: copy tdr into counter.
- tdr  input  CNT_W  reload value.
- ovf_ie  input  1  overflow interrupt enable.
- udf_ie  input  1  underflow interrupt enable.
- ovf_clr  input  1  single-cycle clear of ovf_flag.
- udf_clr  input  1  single-cycle clear of udf_flag.
- tcnt  output  CNT_W  current count, registered.
- ovf_flag  output  1  sticky overflow flag, registered.
- udf_flag  output  1  sticky underflow flag, registered.
- tmr_irq  output  1  (ovf_flag & ovf_ie) | (udf_flag & udf_ie); combinational from registered flags.

Behaviour:
- Reset (presetn=0 at a pclk edge):
  - tcnt=0, ovf_flag=0, udf_flag=0, prescaler=0, so tmr_irq=0.
  - Reset overrides all inputs, including a reset asserted mid-count.
- Prescaler:
  - psc increments by 1 each cycle while en=1 and load=0; wraps modulo 2^PSC_W.
  - Cleared to 0 when en=0 or load=1.
  - mask = 2^(cks+1)-1.
  - tick = en & ~load & ((psc & mask) == mask).
  - First tick occurs 2^(cks+1) cycles after en rises; period thereafter is 2^(cks+1).
  - A cks change mid-run takes effect immediately with the new mask; no psc clear.
- Counter priority per cycle:
  - load > tick > hold.
  - load: tcnt <= tdr next cycle, independent of en.
  - tick & ~cnt_dn: tcnt <= tcnt+1, modulo 2^CNT_W.
  - tick & cnt_dn: tcnt <= tcnt-1, modulo 2^CNT_W.
- Flags:
  - ovf event = tick & ~cnt_dn & tcnt==all-ones (FF->00). ovf_flag set on the same edge tcnt wraps.
  - udf event = tick & cnt_dn & tcnt==0 (00->FF). udf_flag set on the same edge tcnt wraps.
  - Flag update: set wins over clear in the same cycle; otherwise clr=1 -> 0; otherwise hold.
  - A load coincident with a would-be wrap suppresses the event, because no tick occurs.
- tmr_irq is high the cycle after the event edge, i.e. as soon as the flag is visible. It follows ovf_ie/udf_ie changes combinationally.
- Latency summary:
  - load -> tcnt: 1 cycle.
  - tick -> tcnt: 1 cycle.
  - event -> flag: 1 cycle.

Optional Feature:
- Macro: TMR_ONESHOT_EN.
- Defined:
  - Adds input port `oneshot` (1 bit) and internal register `run`.
  - run is set by load or by a rising edge of en, and cleared by reset.
  - When oneshot=1, run clears on an ovf/udf event.
  - tick is additionally gated by run, so the counter stops holding the wrapped value and the prescaler is held at 0.
  - With oneshot=0, behaviour is identical to the undefined build.
- Undefined: no `oneshot` port; continuous wrap-around counting only.

Decomposition:
- Package timer_pkg:
  - CNT_W/PSC_W defaults.
  - cks encodings: CKS_DIV2=0, CKS_DIV4=1, CKS_DIV8=2, CKS_DIV16=3.
  - Direction constants: DIR_UP=0, DIR_DN=1.
- Sub-module timer_prescaler:
  - Inputs: pclk, presetn, en, load, cks.
  - Output: tick.
  - Counter, flag logic and irq stay in timer_counter_core.

Test Plan:
- Reset: presetn=0 for 2 cycles while en=1, load=1, tdr=8'hAA -> tcnt=0, both flags 0, tmr_irq=0. Repeat with reset mid-count at tcnt=8'h05 -> tcnt=0 on the next edge.
- Up count: cks=0, cnt_dn=0, en rises at cycle 0 -> tcnt=1 at cycle 2, tcnt=10 at cycle 20. With cks=3 -> tcnt=1 after 16 cycles.
- Overflow and irq:
  - load tdr=8'hFE, cks=0, up, ovf_ie=1 -> tcnt=FF after 2 cycles, 00 after 4 cycles.
  - ovf_flag=1 and tmr_irq=1 the same cycle tcnt shows 00.
  - ovf_clr pulse -> both drop the next cycle.
- Underflow: load tdr=8'h01, cks=3, cnt_dn=1, udf_ie=0 -> tcnt=00 at 16 cycles, FF at 32 cycles, udf_flag=1, tmr_irq=0. Setting udf_ie=1 -> tmr_irq=1 immediately.
- Simultaneous events:
  - ovf_clr asserted in the cycle of the FF->00 tick -> ovf_flag=1 afterwards.
  - load asserted in the cycle of a tick with tdr=8'h33 -> tcnt=33, no flag set.
- TMR_ONESHOT_EN build: oneshot=1, load tdr=8'hFF, up, cks=0 -> tcnt=00 and ovf_flag=1 at cycle 2; tcnt stays 00 for the next 40 cycles. A new load restarts counting.
